// File: rtl/nibble_inc_sequencer_if.sv
// ----------------------------------------------------------------------------
// nibble_inc_sequencer_if
//   Operand/result stream bundle for nibble_inc_sequencer.
//   Input side : in_valid, in_ready, in_data[WIDTH], in_inc
//   Output side: out_valid, out_ready, out_data[WIDTH], out_co
//   modport slave  : the sequencer (accepts operands, presents results)
//   modport master : the producer/consumer around it
// ----------------------------------------------------------------------------
interface nibble_inc_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_inc;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_co;

    modport slave (
        input  in_valid, in_data, in_inc, out_ready,
        output in_ready, out_valid, out_data, out_co
    );

    modport master (
        output in_valid, in_data, in_inc, out_ready,
        input  in_ready, out_valid, out_data, out_co
    );
endinterface

// File: rtl/nibble_inc_sequencer.sv
// ----------------------------------------------------------------------------
// nibble_inc_sequencer
//   Drives a shared external 4-bit increment cell (S, Co = A + incr) one
//   nibble per clock so that a WIDTH = 4*NIBBLES bit operand is incremented
//   with the carry rippling between cycles, LSB nibble first.
//
//   Ports
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     bus (slave) : in_valid/in_ready/in_data/in_inc operand stream,
//                   out_valid/out_ready/out_data/out_co result stream
//     busy        : state != IDLE
//     inc_a/inc_b : to the increment cell (current nibble / running carry),
//                   both 0 whenever the sequencer is not in RUN
//     inc_s/inc_co: from the increment cell
//
//   Configuration macro: EARLY_EXIT_EN
//     Defined   -> RUN ends as soon as the carry dies (remaining nibbles are
//                  already correct); in_inc=0 goes straight to DONE.
//     Undefined -> always NIBBLES RUN cycles.
//   Results are identical in both builds; only latency differs.
// ----------------------------------------------------------------------------
module nibble_inc_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nibble_inc_sequencer_if.slave        bus,
    output logic                         busy,
    output logic [3:0]                   inc_a,
    output logic                         inc_b,
    input  logic [3:0]                   inc_s,
    input  logic                         inc_co
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [NIBBLES-1:0][3:0]   work_q,  work_d;
    logic [IDX_W-1:0]          idx_q,   idx_d;
    logic                      carry_q, carry_d;
    logic                      out_co_q, out_co_d;

    // Next-state logic.
    always_comb begin
        // NOTE: every _d takes its held value first, so paths that don't
        // assign it cannot infer a latch.
        state_d  = state_q;
        work_d   = work_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        out_co_d = out_co_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    work_d   = bus.in_data;
                    carry_d  = bus.in_inc;
                    idx_d    = '0;
                    out_co_d = 1'b0;
`ifdef EARLY_EXIT_EN
                    // Nothing to add: the operand is already the result.
                    state_d  = bus.in_inc ? S_RUN : S_DONE;
`else
                    state_d  = S_RUN;
`endif
                end
            end

            S_RUN: begin
                work_d[idx_q] = inc_s;
                carry_d       = inc_co;
                if (idx_q == LAST_IDX) begin
                    state_d  = S_DONE;
                    out_co_d = inc_co;
                end
`ifdef EARLY_EXIT_EN
                else if (!inc_co) begin
                    // Carry died: higher nibbles are unchanged and no carry
                    // can leave the MSB.
                    state_d  = S_DONE;
                    out_co_d = 1'b0;
                end
`endif
                else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            // NOTE: the operand register is reset as well, so out_data and
            // inc_a come up at a defined 0 rather than X after reset.
            work_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            out_co_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every flop samples the
            // pre-edge values computed by the comb block.
            state_q  <= state_d;
            work_q   <= work_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            out_co_q <= out_co_d;
        end
    end

    // Outputs decoded from registers only.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = work_q;
    assign bus.out_co    = out_co_q;
    assign busy          = (state_q != S_IDLE);

    // The cell is shared, so it sees zeros outside RUN.
    assign inc_a = (state_q == S_RUN) ? work_q[idx_q] : 4'h0;
    assign inc_b = (state_q == S_RUN) ? carry_q       : 1'b0;

endmodule
